siganfu_turret_controller: RTL
==============================

Name: siganfu_turret_controller

Overview:
- Parametrised fire-control FSM for a Siganfu weapon channel, sitting between the targeting/sensor front end and the trigger actuator.
- Generalises the single/auto gun controller with three firing modes (single, burst, auto) and configurable magazine size and count.
- All pulse, gap, reload and cooldown times are cycle-counted and fully synchronous; there are no delay-based timings.
- Exposes ammo counters for the HUD, plus a sticky criticality alert.

Parameters:
- MAG_SIZE, 25, rounds per magazine (>=1).
- MAG_COUNT, 3, spare magazines after reset (>=0).
- PULSE_CYC, 5, fire_trigger high time per shot, in cycles (>=1).
- GAP_CYC, 1, minimum low cycles between shots (>=1).
- BURST_LEN, 3, shots per burst (>=1).
- RELOAD_CYC, 50, cycles spent in RELOAD (>=1).
- COOL_CYC, 100, cycles spent in COOLDOWN (>=1).

Ports:
- sysclk  in  1  clock; everything updates on the rising edge.
- reboot  in  1  synchronous, active-high reset.
- target_locked  in  1  target lock indication.
- is_enemy  in  1  IFF says hostile.
- fire_command  in  1  operator trigger, level.
- firing_mode  in  2  00 single, 01 burst, 10 auto, 11 treated as single.
- overheat_sensor  in  1  barrel overheat, level.
- current_state  out  3  FSM state (encodings below).
- criticality_alert  out  1  sticky: last magazine loaded.
- fire_trigger  out  1  registered actuator pulse.
- bullets_left  out  $clog2(MAG_SIZE+1)  rounds in the current magazine.
- magazines_left  out  $clog2(MAG_COUNT+1)  spare magazines.

Behaviour:
- Definitions:
  - engage = is_enemy & target_locked & fire_command.
  - idle_ok = shot timer is zero, i.e. no pulse or gap in progress.
- Reset (reboot=1 at an edge; overrides everything, from any state and mid-pulse):
  - current_state=IDLE, bullets_left=MAG_SIZE, magazines_left=MAG_COUNT.
  - fire_trigger=0, criticality_alert=0, shot timer=0, burst count=0, armed=1.
- armed: cleared on IDLE->SINGLE and on IDLE->BURST; set on any edge where fire_command=0. This gives one single shot or one burst per trigger press.
- State encodings: IDLE 000, SINGLE 001, AUTO 010, RELOAD 011, COOLDOWN 100, DOWNFALL 101, BURST 110.
- Shot issue at edge E:
  - bullets_left decrements by 1 at E.
  - fire_trigger is high for exactly PULSE_CYC cycles following E, then low.
  - The next issue is allowed no earlier than edge E+PULSE_CYC+GAP_CYC.
  - A pulse or gap in progress always completes. No transition out of a firing state occurs unless idle_ok; reboot is the only exception.
- IDLE transitions:
  - engage & bullets_left>0:
    - mode 10 -> AUTO.
    - mode 01 & armed -> BURST, loading burst count=BURST_LEN.
    - mode 00/11 & armed -> SINGLE.
  - Otherwise stay in IDLE.
  - IDLE never issues a shot. The first shot comes at the edge after entry, provided engage still holds, so engage-to-trigger latency is 2 edges.
- Firing states: evaluate in this priority order at each edge with idle_ok:
  1. overheat_sensor -> COOLDOWN.
  2. bullets_left==0 -> RELOAD if magazines_left>0, else DOWNFALL.
  3. State-specific rule:
     - SINGLE: if no shot has been issued yet in this visit and engage, issue a shot; otherwise -> IDLE.
     - BURST: if burst count>0 and is_enemy & target_locked, issue a shot and decrement burst count. Releasing fire_command does not abort a burst; losing lock or IFF does. Otherwise -> IDLE.
     - AUTO: issue a shot while engage; when engage drops -> IDLE.
- RELOAD:
  - Lasts RELOAD_CYC cycles.
  - On the exit edge: bullets_left=MAG_SIZE, magazines_left decrements by 1, and criticality_alert is set if the new magazines_left==0. The alert stays high until reboot.
  - Then -> IDLE. A held engage in auto mode resumes firing via IDLE.
- COOLDOWN: lasts COOL_CYC cycles, then -> IDLE, regardless of overheat_sensor level. If still hot, the next firing state re-enters COOLDOWN.
- DOWNFALL: terminal, fire_trigger=0; only reboot leaves it.
- Counters:
  - Counters never wrap. bullets_left never decrements below 0; magazines_left never goes below 0.
  - Timers are sized for max(PULSE_CYC+GAP_CYC, RELOAD_CYC, COOL_CYC).
- Simultaneous events: reboot > overheat > empty > mode logic. A mode change while in a firing state has no effect until the next return to IDLE.

Test Plan:
Bench parameters for all scenarios: MAG_SIZE=4, MAG_COUNT=1, PULSE_CYC=2, GAP_CYC=1, BURST_LEN=3, RELOAD_CYC=5, COOL_CYC=6.
1. Single shot: mode 00, engage held for 20 cycles -> exactly one 2-cycle fire_trigger pulse and bullets 4->3. Release fire_command, then re-press -> a second pulse and bullets 3->2.
2. Burst: mode 01, engage pulsed for 1 cycle only -> 3 pulses spaced 3 cycles apart, bullets 4->1, then IDLE.
3. Auto and reload: mode 10, engage held -> 4 pulses; RELOAD entered with state=011 for 5 cycles. On exit bullets=4, magazines=0 and criticality_alert=1; firing resumes. After 4 more shots -> DOWNFALL (101) and fire_trigger stays 0.
4. Overheat: AUTO with overheat asserted mid-pulse -> the pulse completes, then COOLDOWN (100) for 6 cycles, then IDLE.
5. Reboot from DOWNFALL, and reboot mid-pulse -> next cycle: state=000, fire_trigger=0, bullets=4, magazines=1, alert=0.
6. Auto with is_enemy dropping between shots -> no further pulses; return to IDLE once the gap completes.

Source files
------------

// File: rtl/siganfu_turret_controller.sv
// siganfu_turret_controller: single/burst/auto fire-control FSM with magazines, reload, cooldown and criticality alert
module siganfu_turret_controller #(
  parameter int MAG_SIZE   = 25,
  parameter int MAG_COUNT  = 3,
  parameter int PULSE_CYC  = 5,
  parameter int GAP_CYC    = 1,
  parameter int BURST_LEN  = 3,
  parameter int RELOAD_CYC = 50,
  parameter int COOL_CYC   = 100
) (
  input  logic                           sysclk,
  input  logic                           reboot,
  input  logic                           target_locked,
  input  logic                           is_enemy,
  input  logic                           fire_command,
  input  logic [1:0]                     firing_mode,
  input  logic                           overheat_sensor,
  output logic [2:0]                     current_state,
  output logic                           criticality_alert,
  output logic                           fire_trigger,
  output logic [$clog2(MAG_SIZE+1)-1:0]  bullets_left,
  output logic [$clog2(MAG_COUNT+1)-1:0] magazines_left
);
  localparam int BW   = $clog2(MAG_SIZE+1);
  localparam int MW   = $clog2(MAG_COUNT+1);
  localparam int BLW  = $clog2(BURST_LEN+1);
  localparam int SHOT = PULSE_CYC + GAP_CYC;
  localparam int TMAX = SHOT > RELOAD_CYC ? (SHOT > COOL_CYC ? SHOT : COOL_CYC)
                                          : (RELOAD_CYC > COOL_CYC ? RELOAD_CYC : COOL_CYC);
  localparam int TW   = $clog2(TMAX+1);

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    SINGLE   = 3'b001,
    AUTO     = 3'b010,
    RELOAD   = 3'b011,
    COOLDOWN = 3'b100,
    DOWNFALL = 3'b101,
    BURST    = 3'b110
  } state_t;

  state_t         state_q;
  logic [BW-1:0]  bullets_q;
  logic [MW-1:0]  mags_q;
  logic [TW-1:0]  timer_q;
  logic [BLW-1:0] burst_q;
  logic           fire_q, alert_q, armed_q, shot_q;
  logic           engage, shoot;

  assign engage = is_enemy & target_locked & fire_command;
  assign shoot  = state_q == SINGLE ? (!shot_q && engage)
                : state_q == BURST  ? (burst_q != '0 && is_enemy && target_locked)
                : engage;

  assign current_state     = state_q;
  assign criticality_alert = alert_q;
  assign fire_trigger      = fire_q;
  assign bullets_left      = bullets_q;
  assign magazines_left    = mags_q;

  // One timer serves both the shot pulse/gap and the reload/cooldown dwell; fire is high while the shot timer is above the gap
  always_ff @(posedge sysclk) begin
    if (reboot) begin
      state_q   <= IDLE;
      bullets_q <= BW'(MAG_SIZE);
      mags_q    <= MW'(MAG_COUNT);
      timer_q   <= '0;
      burst_q   <= '0;
      fire_q    <= 1'b0;
      alert_q   <= 1'b0;
      armed_q   <= 1'b1;
      shot_q    <= 1'b0;
    end else begin
      fire_q <= 1'b0;
      if (!fire_command) armed_q <= 1'b1;
      case (state_q)
        IDLE:
          if (engage && bullets_q != '0) begin
            if (firing_mode == 2'b10) state_q <= AUTO;
            else if (armed_q && firing_mode == 2'b01) begin
              state_q <= BURST;
              burst_q <= BLW'(BURST_LEN);
              armed_q <= 1'b0;
            end else if (armed_q) begin
              state_q <= SINGLE;
              shot_q  <= 1'b0;
              armed_q <= 1'b0;
            end
          end
        SINGLE, BURST, AUTO:
          if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
            fire_q  <= timer_q > TW'(GAP_CYC);
          end else if (overheat_sensor) begin
            state_q <= COOLDOWN;
            timer_q <= TW'(COOL_CYC-1);
          end else if (bullets_q == '0) begin
            state_q <= mags_q != '0 ? RELOAD : DOWNFALL;
            timer_q <= mags_q != '0 ? TW'(RELOAD_CYC-1) : '0;
          end else if (shoot) begin
            bullets_q <= bullets_q - 1'b1;
            timer_q   <= TW'(SHOT-1);
            fire_q    <= 1'b1;
            shot_q    <= 1'b1;
            if (state_q == BURST) burst_q <= burst_q - 1'b1;
          end else state_q <= IDLE;
        RELOAD:
          if (timer_q != '0) timer_q <= timer_q - 1'b1;
          else begin
            state_q   <= IDLE;
            bullets_q <= BW'(MAG_SIZE);
            mags_q    <= mags_q - 1'b1;
            alert_q   <= alert_q | (mags_q == MW'(1));
          end
        COOLDOWN:
          if (timer_q != '0) timer_q <= timer_q - 1'b1;
          else state_q <= IDLE;
        DOWNFALL: state_q <= DOWNFALL;
        default:  state_q <= IDLE;
      endcase
    end
  end
endmodule
